// File: rtl/daq_pkg.sv
// Shared definitions for the DAQ pin sampler: record layout, record length and FSM encoding.
package daq_pkg;

  localparam int unsigned REC_WORDS = 2;

  localparam int unsigned ID_LSB   = 24;
  localparam int unsigned LOST_LSB = 16;
  localparam int unsigned PINS_LSB = 0;

  typedef enum logic [1:0] {
    StIdle,
    StReq,
    StW0,
    StW1
  } daq_state_e;

  function automatic logic [31:0] pack_word0(input logic [7:0]  id,
                                             input logic [7:0]  lost,
                                             input logic [15:0] pins);
    logic [31:0] w;
    w                  = '0;
    w[ID_LSB +: 8]     = id;
    w[LOST_LSB +: 8]   = lost;
    w[PINS_LSB +: 16]  = pins;
    return w;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO, WIDTH x 2^ADDR_BITS, with registered read of the head entry.
module sync_fifo #(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned ADDR_BITS = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int unsigned Depth = 1 << ADDR_BITS;

  logic [WIDTH-1:0]   mem [Depth];
  logic [ADDR_BITS:0] wptr_q, rptr_q;
  logic               push_ok, pop_ok;

  assign empty   = (wptr_q == rptr_q);
  assign full    = (wptr_q[ADDR_BITS] != rptr_q[ADDR_BITS]) &&
                   (wptr_q[ADDR_BITS-1:0] == rptr_q[ADDR_BITS-1:0]);
  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
  assign push_ok = push && (!full || pop);
  assign pop_ok  = pop && !empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (push_ok) wptr_q <= wptr_q + 1'b1;
      if (pop_ok)  rptr_q <= rptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wptr_q[ADDR_BITS-1:0]] <= wdata;
  end

  always_ff @(posedge clk) begin
    rdata <= mem[rptr_q[ADDR_BITS-1:0]];
  end

endmodule

// File: rtl/daq_pin_sampler.sv
// Samples asynchronous pins, queues a timestamped record per change and streams each record
// as two words to one slot of the DAQ aggregator.
module daq_pin_sampler
  import daq_pkg::*;
#(
  parameter int unsigned NPINS      = 8,
  parameter int unsigned FIFO_BITS  = 4,
  parameter logic [7:0]  CHANNEL_ID = 8'h01
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      systime,
  input  logic             enable,
  input  logic [NPINS-1:0] pins,
  output logic [31:0]      daq_data,
  output logic             daq_valid,
  output logic             daq_end,
  output logic             daq_req,
  input  logic             daq_grant
);

  localparam int unsigned RecWidth = 32 + NPINS;

  logic [NPINS-1:0]    s1_q, s2_q, last_q;
  logic                primed_q;
  logic [7:0]          lost_q, lost_d;
  daq_state_e          state_q, state_d;
  logic [31:0]         data_q, data_d;
  logic                valid_q, valid_d, end_q, end_d, req_q, req_d;
  logic                push, pop, drop;
  logic                fifo_full, fifo_empty;
  logic [RecWidth-1:0] fifo_rdata;

  // Synchronizer is left out of reset so priming sees live pin values.
  always_ff @(posedge clk) begin
    s1_q <= pins;
    s2_q <= s1_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_q   <= '0;
      primed_q <= 1'b0;
    end else begin
      last_q   <= s2_q;
      primed_q <= 1'b1;
    end
  end

  assign push = primed_q && enable && (s2_q != last_q);
  assign drop = push && fifo_full && !pop;

  sync_fifo #(
    .WIDTH     (RecWidth),
    .ADDR_BITS (FIFO_BITS)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .wdata ({systime, s2_q}),
    .pop   (pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_comb begin
    lost_d = lost_q;
    if (state_q == StW0) begin
      lost_d = drop ? 8'd1 : 8'd0;
    end else if (drop && (lost_q != 8'hFF)) begin
      lost_d = lost_q + 8'd1;
    end
  end

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    valid_d = 1'b0;
    end_d   = 1'b0;
    data_d  = data_q;
    pop     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (!fifo_empty) begin
          state_d = StReq;
          req_d   = 1'b1;
        end
      end
      StReq: begin
        if (daq_grant) state_d = StW0;
      end
      StW0: begin
        valid_d = 1'b1;
        data_d  = pack_word0(CHANNEL_ID, lost_q, 16'(fifo_rdata[NPINS-1:0]));
        // Read data still shows the popped head next cycle, which supplies word1.
        pop     = 1'b1;
        state_d = StW1;
      end
      StW1: begin
        valid_d = 1'b1;
        end_d   = 1'b1;
        data_d  = fifo_rdata[NPINS +: 32];
        req_d   = 1'b0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      lost_q  <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      end_q   <= 1'b0;
      req_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      lost_q  <= lost_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      end_q   <= end_d;
      req_q   <= req_d;
    end
  end

  assign daq_data  = data_q;
  assign daq_valid = valid_q;
  assign daq_end   = end_q;
  assign daq_req   = req_q;

endmodule

// File: tb/tb_daq_pin_sampler.sv
// Scoreboard bench for daq_pin_sampler: records queued at stimulus time, checked on output.
module tb_daq_pin_sampler;
  import daq_pkg::*;

  localparam int unsigned NPINS     = 8;
  localparam int unsigned FIFO_BITS = 4;
  localparam int unsigned Depth     = 1 << FIFO_BITS;
  localparam logic [7:0]  ChId      = 8'h01;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [31:0]      systime = 32'd0;
  logic             enable = 1'b0;
  logic [NPINS-1:0] pins = '0;
  logic             daq_grant = 1'b0;
  logic [31:0]      daq_data;
  logic             daq_valid, daq_end, daq_req;

  typedef struct {
    logic [7:0]  pins;
    logic [31:0] ts;
  } rec_t;

  rec_t        exp_q[$];
  int          n_checks = 0;
  int          n_errors = 0;
  int          lost_model = 0;
  int          widx = 0;
  logic [31:0] cur_ts = '0;

  daq_pin_sampler #(
    .NPINS      (NPINS),
    .FIFO_BITS  (FIFO_BITS),
    .CHANNEL_ID (ChId)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .systime   (systime),
    .enable    (enable),
    .pins      (pins),
    .daq_data  (daq_data),
    .daq_valid (daq_valid),
    .daq_end   (daq_end),
    .daq_req   (daq_req),
    .daq_grant (daq_grant)
  );

  // Posedge at 10n+5, systime steps at 10n+8, bench acts on negedge at 10n.
  initial begin
    forever begin
      #5 clk = 1'b1;
      #3 systime = systime + 32'd1;
      #2 clk = 1'b0;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Called on a negedge; the change is sampled at the next posedge and pushed two edges later.
  task automatic set_pins(input logic [7:0] v, input bit expect_rec);
    rec_t r;
    pins = v;
    if (expect_rec) begin
      if (exp_q.size() >= Depth) begin
        if (lost_model < 255) lost_model++;
      end else begin
        r.pins = v;
        r.ts   = systime + 32'd2;
        exp_q.push_back(r);
      end
    end
  endtask

  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || widx != 0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("drain_timeout", exp_q.size(), 0);
  endtask

  always @(negedge clk) begin
    rec_t e;
    if (rst) begin
      widx = 0;
    end else if (daq_valid) begin
      if (widx == 0) begin
        if (exp_q.size() == 0) begin
          check("spurious_valid", {31'd0, daq_valid}, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("word0", daq_data, {ChId, 8'(lost_model), 8'h00, e.pins});
          check("end_on_word0", {31'd0, daq_end}, 32'd0);
          check("req_on_word0", {31'd0, daq_req}, 32'd1);
          lost_model = 0;
          cur_ts     = e.ts;
          widx       = 1;
        end
      end else begin
        check("word1", daq_data, cur_ts);
        check("end_on_last", {31'd0, daq_end}, (widx == REC_WORDS - 1) ? 32'd1 : 32'd0);
        check("req_on_last", {31'd0, daq_req}, 32'd0);
        widx = 0;
      end
    end else if (widx != 0) begin
      check("truncated_record", {31'd0, daq_valid}, 32'd1);
      widx = 0;
    end
  end

  initial begin
    int  req_at, val_at, low, n;
    bit  req_seen;

    // 1: reset values and priming
    enable    = 1'b1;
    daq_grant = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_data",  daq_data, 32'd0);
    check("rst_valid", {31'd0, daq_valid}, 32'd0);
    check("rst_end",   {31'd0, daq_end}, 32'd0);
    check("rst_req",   {31'd0, daq_req}, 32'd0);
    rst = 1'b0;
    req_seen = 1'b0;
    repeat (100) begin
      @(negedge clk);
      req_seen |= daq_req;
    end
    check("prime_no_req", {31'd0, req_seen}, 32'd0);

    // 2: single change at systime 1000, grant held high
    while (systime < 32'd1000) @(negedge clk);
    check("systime_align", systime, 32'd1000);
    set_pins(8'h5A, 1'b1);
    req_at = -1;
    val_at = -1;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      if (daq_req && req_at < 0) req_at = i;
      if (daq_valid && val_at < 0) val_at = i;
    end
    check("req_latency",   req_at, 4);
    check("valid_latency", val_at, 6);
    wait_drain(50);

    // 3: overflow with grant low, 20 changes into 16 slots
    daq_grant = 1'b0;
    for (int i = 0; i < 20; i++) begin
      set_pins(8'h80 + 8'(i), 1'b1);
      @(negedge clk);
    end
    repeat (5) @(negedge clk);
    check("ovf_req_waiting", {31'd0, daq_req}, 32'd1);
    check("ovf_lost_model", lost_model, 4);
    daq_grant = 1'b1;
    wait_drain(300);

    // 4: changes while disabled are absorbed silently
    enable = 1'b0;
    set_pins(8'hFF, 1'b0);
    repeat (5) @(negedge clk);
    enable = 1'b1;
    req_seen = 1'b0;
    repeat (10) begin
      @(negedge clk);
      req_seen |= daq_req;
    end
    check("enable_no_req", {31'd0, req_seen}, 32'd0);
    set_pins(8'hFE, 1'b1);
    wait_drain(50);

    // 5: reset in the middle of a record
    set_pins(8'h11, 1'b1);
    n = 0;
    while (!daq_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("w0_seen_before_rst", {31'd0, daq_valid}, 32'd1);
    #1 rst = 1'b1;
    @(negedge clk);
    check("midrst_valid", {31'd0, daq_valid}, 32'd0);
    check("midrst_end",   {31'd0, daq_end}, 32'd0);
    check("midrst_req",   {31'd0, daq_req}, 32'd0);
    #1 rst = 1'b0;
    exp_q.delete();
    lost_model = 0;
    req_seen = 1'b0;
    repeat (30) begin
      @(negedge clk);
      req_seen |= daq_req | daq_valid;
    end
    check("midrst_fifo_empty", {31'd0, req_seen}, 32'd0);

    // 6: two queued records, one grant pulse per request
    daq_grant = 1'b0;
    set_pins(8'h22, 1'b1);
    repeat (2) @(negedge clk);
    set_pins(8'h33, 1'b1);
    repeat (6) @(negedge clk);
    for (int r = 0; r < 2; r++) begin
      n = 0;
      while (!daq_req && n < 20) begin
        @(negedge clk);
        n++;
      end
      check("b2b_req", {31'd0, daq_req}, 32'd1);
      daq_grant = 1'b1;
      @(negedge clk);
      daq_grant = 1'b0;
      n = 0;
      while (!(daq_valid && daq_end) && n < 20) begin
        @(negedge clk);
        n++;
      end
      check("b2b_end_seen", {31'd0, daq_valid & daq_end}, 32'd1);
      if (r == 0) begin
        low = 0;
        while (!daq_req && low < 10) begin
          low++;
          @(negedge clk);
        end
        check("b2b_req_gap", low, 1);
      end
    end
    wait_drain(50);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/daq_pin_sampler.md
Name: daq_pin_sampler

Overview:
Upstream DAQ source channel that watches NPINS asynchronous digital inputs and records every change as a timestamped two-word record. Records are buffered in a small internal FIFO and delivered to one slot of the daq aggregator over its req/grant/valid/end channel. The daq aggregator then packs them for the mac. Lost events caused by FIFO overflow are counted and reported in the next record delivered.

Parameters:
NPINS, 8, number of sampled pins; legal range 1..16
FIFO_BITS, 4, log2 of record FIFO depth (default 16 records)
CHANNEL_ID, 8'h01, tag placed in word0[31:24]

Ports:
clk  in  1  system clock (48 MHz)
rst  in  1  synchronous reset, active-high
systime  in  32  free-running system time, sampled as the timestamp
enable  in  1  1 = record pin changes; 0 = no new records
pins  in  NPINS  asynchronous inputs
daq_data  out  32  record word to daq
daq_valid  out  1  daq_data valid this cycle
daq_end  out  1  last word of record (asserted together with daq_valid)
daq_req  out  1  request for the daq output slot
daq_grant  in  1  slot granted by daq

Behaviour:
- Reset values: daq_data=0, daq_valid=0, daq_end=0, daq_req=0. Reset also empties the FIFO, clears lost_cnt, clears the prime flag and forces the FSM to IDLE. A reset mid-record abandons the record; no partial end is emitted.
- Every output is driven from a register.
- Synchronizer: pins pass through 2 flops (s1, s2). A change latched into s1 at edge k appears in s2 at edge k+1.
- Priming: the first s2 value after reset loads last_pins and generates no event. The prime flag is then set.
- Change detect: primed, s2 != last_pins, enable=1 → push {systime, s2} at edge k+2. last_pins <= s2 on every cycle, whether or not enable is high. Toggling enable therefore never produces a spurious event.
- Overflow: if a push is attempted while the FIFO is full, the record is dropped and lost_cnt (8 bits) increments, saturating at 255.
- Record format:
  - word0 = {CHANNEL_ID[7:0], lost_cnt[7:0], pins zero-extended to 16 bits}
  - word1 = systime captured at the push cycle
- lost_cnt handling when word0 is emitted: the value sent is the counter value at that cycle, and the counter clears. A drop in that same cycle leaves the counter at 1.
- FSM states: IDLE, REQ, W0, W1.
  - IDLE: FIFO not empty → REQ, daq_req<=1.
  - REQ: hold daq_req. When daq_grant=1 is sampled → W0, registering daq_valid=1 with daq_data=word0.
  - W0 → W1: daq_valid=1, daq_data=word1, daq_end=1, daq_req<=0. The FIFO pops on this transition.
  - W1 → IDLE: valid and end drop to 0.
  - Back-to-back records: after returning to IDLE, daq_req rises one cycle later if the FIFO is still non-empty.
- Grant contract: daq holds grant until end. If grant drops during W0 or W1, the record still completes.
- Latency from the change (edge k):
  - FIFO write at k+2.
  - daq_req high after k+3.
  - With grant already high, word0 is valid after k+5 and word1 after k+6.
- FIFO:
  - Simultaneous push and pop are permitted while full; the pop frees the slot, so the push succeeds.
  - FIFO read data is available the cycle after the pointer moves; word0 is sourced from the head entry.
- The daq_data value when daq_valid=0 is don't-care. Hold the last word rather than toggling.

Decomposition:
- Shared package daq_pkg holds the record field offsets (ID, LOST, PINS), the record length constant (2 words) and the FSM state encoding.
- Natural sub-module: sync_fifo, a parameterized width×2^FIFO_BITS FIFO with full, empty, push, pop and registered read, instantiated here at width 32+NPINS.
- The synchronizer and the FSM stay inline.

Test Plan:
1. Reset, then pins=8'h00 with enable=1 and no change, grant held high for 100 cycles → daq_req never asserts; priming emits no record.
2. pins 8'h00→8'h5A at systime=1000 with grant tied high → word0=32'h0100005A, then word1=1002 with end=1; daq_req drops with end.
3. 20 distinct changes 1 cycle apart with grant low (FIFO_BITS=4) → 16 records stored and 4 lost; on granting, the first word0 carries lost=8'h04 and the second carries lost=8'h00.
4. enable=0, pins toggled to 8'hFF, then enable=1 with no further change → no record; the next change to 8'hFE produces a record with pins 16'h00FE.
5. Grant asserted, rst pulsed during W0 → valid, end and req are 0 the cycle after reset; the FIFO is empty; no further records until a new pin change.
6. Two queued records, grant pulsed per request → the sequence is W0, W1, IDLE, REQ; daq_req low for exactly one cycle between records; each end coincides with the second valid word.
